pipe_decode: RTL and testbench
==============================

# pipe_decode

Parametrised, pipelined successor to the single-cycle decode stage. It accepts one instruction per cycle from fetch over a valid/ready handshake and decodes it. It reads an internal register file with write-before-read bypass, extends the immediate, and detects load-use hazards. Results land in a registered ID/EX output that is held under downstream backpressure. It sits between the fetch stage and the execute stage, and takes writeback directly from the WB stage.

## Interface
- `DATA_W`, 16: register, immediate and PC width (≥16).
- `CTRL_W`, 24: width of the opaque control word passed to execute.
- `ZERO_R0`, 0: when 1, R0 reads as zero and writes to R0 are dropped.
- `BYPASS`, 1: when 1, a same-cycle WB write to a read register is forwarded.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: decode accepts the instruction this cycle.
- `instr` input 16: instruction word. Fixed ISA fields: rs=[10:8], rt=[7:5], rd=[4:2].
- `pc2` input DATA_W: PC+2 of `instr`.
- `wb_en` input 1: register write enable.
- `wb_reg` input 3: register to write.
- `wb_data` input DATA_W: data to write.
- `flush` input 1: squash the instruction being decoded and the output register.
- `out_valid` output 1: the ID/EX register holds a live instruction.
- `out_ready` input 1: execute consumes the output this cycle.
- `out_a`, `out_b` output DATA_W: rs and rt read data.
- `out_imm` output DATA_W: extended immediate.
- `out_wreg` output 3: destination register.
- `out_wen` output 1: the instruction writes a register.
- `out_load` output 1: the instruction is a load.
- `out_ctrl` output CTRL_W: remaining execute/memory control bits.
- `out_pc2` output DATA_W: registered copy of `pc2`.

## Operation
- **Control decode.**
  - `decode_ctrl` maps `instr[15:11]` (and `instr[1:0]` for R-type) to `uses_rs`, `uses_rt`, `imm_kind`, `zext`, `dest_sel`, `wen`, `load` and `ctrl`.
  - Illegal opcodes decode as a NOP with `wen=0` and `load=0`.
- **Destination select.** `dest_sel` picks the destination: 0 → instr[7:5], 1 → instr[10:8], 2 → instr[4:2], 3 → R7.
- **Immediate.** `imm_kind` NONE/IMM5/IMM8/IMM11 selects instr[4:0], [7:0] or [10:0]. The field is zero- or sign-extended to DATA_W; IMM11 is always sign-extended.
- **Register file.**
  - 8×DATA_W; all entries become 0 on reset.
  - Writes occur at posedge when `rst=1` and `wb_en=1`.
  - Read bypass, when `BYPASS=1`: if `wb_en` is set and `wb_reg` equals the read select, the read returns `wb_data` combinationally.
- **Load-use hazard.**
  - `hazard = in_valid & out_valid & out_load & out_wen & ((uses_rs & rs==out_wreg) | (uses_rt & rt==out_wreg))`.
  - When `ZERO_R0=1`, a match on R0 is not a hazard.
- **Handshake.**
  - `advance = !out_valid | out_ready`.
  - `in_ready = rst & advance & (!hazard | flush)`.
- **Output register update** at each posedge:
  - When `rst=0`: clear all outputs and set `out_valid=0`.
  - When `flush` is asserted: set `out_valid=0`. The presented instruction is consumed (`in_ready=1`) and discarded. Writeback still occurs.
  - When `advance & hazard`: set `out_valid=0`, inserting a bubble. The instruction stays at the input.
  - When `advance & in_valid & in_ready`: load the decoded fields and set `out_valid=1`.
  - When `advance & !in_valid`: set `out_valid=0`.
  - When `!advance`: hold every output bit-stable.
- **Priority:** reset > flush > hazard > accept.
- **Reset mid-operation:** the in-flight output is dropped and a WB write in a reset cycle is ignored.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `out_*` after edge N.
- Throughput is 1 instruction per cycle with no hazard and `out_ready=1`.
- A load-use hazard costs exactly one bubble cycle. The next edge moves the load out, the hazard clears, and the dependent instruction is accepted.
- `in_ready` is combinational from `in_valid`, `instr`, `flush`, `out_ready` and state. `out_*` are registered only, with no path from inputs to outputs.
- A WB write and a read of the same register in the same cycle:
  - `BYPASS=1`: the read returns the new data.
  - `BYPASS=0`: the read returns the old data, and the new value is visible the next cycle.

## Structure
- Package `decode_pkg` holds:
  - opcode constants;
  - `imm_kind_t` (NONE, IMM5, IMM8, IMM11);
  - `dest_sel_t` (RT, RS, RD, R7);
  - the control-word field layout and `CTRL_W`.
- Sub-module `decode_ctrl` is purely combinational opcode decode. The register file, bypass, hazard logic and ID/EX register are inline.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles. Then `out_valid=0` and all outputs are 0, `in_ready=0` during reset, and reading R1–R7 afterwards returns 0.
- **Back-to-back:** stream 3 ADDI with `out_ready=1`. Expect `out_valid` high for 3 consecutive cycles, each `out_imm` correctly sign-extended, and imm5 `5'b10000` giving `16'hFFF0`.
- **Bypass:** `wb_en=1`, `wb_reg=3`, `wb_data=16'hBEEF` in the same cycle as decoding an instruction with rs=3. Expect `out_a=16'hBEEF` with `BYPASS=1`, and 0 with `BYPASS=0`.
- **Load-use:** a LD to R2, then an ADD reading R2. Expect exactly one cycle with `out_valid=0`, then the ADD issues. An ADD with `uses_rt=0` that does not read R2 issues with no bubble.
- **Backpressure:** hold `out_ready=0` for 3 cycles. Expect outputs bit-stable and `in_ready=0`. When released, expect the next instruction one cycle later with no loss or duplicate.
- **Flush during hazard:** assert `flush` in the hazard cycle. Expect `in_ready=1`, the instruction discarded, and the next cycle `out_valid=0` while the WB write still lands.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate/destination selectors and the
// control-word layout handed to execute.
package decode_pkg;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_ADDI  = 5'd1;
  localparam logic [4:0] OP_ANDI  = 5'd2;
  localparam logic [4:0] OP_LD    = 5'd3;
  localparam logic [4:0] OP_ST    = 5'd4;
  localparam logic [4:0] OP_LI    = 5'd5;
  localparam logic [4:0] OP_ADDI8 = 5'd6;
  localparam logic [4:0] OP_BEQ   = 5'd7;
  localparam logic [4:0] OP_JAL   = 5'd8;
  localparam logic [4:0] OP_JR    = 5'd9;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_PASSB = 4'd4;

  typedef enum logic [1:0] {IMM_NONE, IMM5, IMM8, IMM11} imm_kind_t;
  typedef enum logic [1:0] {DST_RT, DST_RS, DST_RD, DST_R7} dest_sel_t;

  // R-type funct[1:0] maps directly onto alu_op[1:0].
  typedef struct packed {
    logic [11:0] rsvd;
    logic [3:0]  alu_op;
    logic        alu_imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        link;
    logic        legal;
    logic        rtype;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_ctrl.sv
// Purely combinational opcode decode; unknown opcodes fall out as a NOP that
// neither writes a register nor loads.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [4:0] op,
  input  logic [1:0] funct,
  output logic       uses_rs,
  output logic       uses_rt,
  output imm_kind_t  imm_kind,
  output logic       zext,
  output dest_sel_t  dest_sel,
  output logic       wen,
  output logic       load,
  output ctrl_t      ctrl
);

  always_comb begin
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    imm_kind = IMM_NONE;
    zext     = 1'b0;
    dest_sel = DST_RT;
    wen      = 1'b0;
    load     = 1'b0;
    ctrl     = '0;
    case (op)
      OP_RTYPE: begin
        uses_rs = 1'b1; uses_rt = 1'b1; dest_sel = DST_RD; wen = 1'b1;
        ctrl.alu_op = {2'b00, funct}; ctrl.rtype = 1'b1;
      end
      OP_ADDI: begin
        uses_rs = 1'b1; imm_kind = IMM5; wen = 1'b1;
        ctrl.alu_op = ALU_ADD; ctrl.alu_imm = 1'b1;
      end
      OP_ANDI: begin
        uses_rs = 1'b1; imm_kind = IMM5; zext = 1'b1; wen = 1'b1;
        ctrl.alu_op = ALU_AND; ctrl.alu_imm = 1'b1;
      end
      OP_LD: begin
        uses_rs = 1'b1; imm_kind = IMM5; wen = 1'b1; load = 1'b1;
        ctrl.alu_op = ALU_ADD; ctrl.alu_imm = 1'b1; ctrl.mem_rd = 1'b1;
      end
      OP_ST: begin
        uses_rs = 1'b1; uses_rt = 1'b1; imm_kind = IMM5;
        ctrl.alu_op = ALU_ADD; ctrl.alu_imm = 1'b1; ctrl.mem_wr = 1'b1;
      end
      OP_LI: begin
        imm_kind = IMM8; zext = 1'b1; dest_sel = DST_RS; wen = 1'b1;
        ctrl.alu_op = ALU_PASSB; ctrl.alu_imm = 1'b1;
      end
      OP_ADDI8: begin
        uses_rs = 1'b1; imm_kind = IMM8; dest_sel = DST_RS; wen = 1'b1;
        ctrl.alu_op = ALU_ADD; ctrl.alu_imm = 1'b1;
      end
      OP_BEQ: begin
        uses_rs = 1'b1; uses_rt = 1'b1; imm_kind = IMM5;
        ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1;
      end
      OP_JAL: begin
        imm_kind = IMM11; dest_sel = DST_R7; wen = 1'b1;
        ctrl.jump = 1'b1; ctrl.link = 1'b1;
      end
      OP_JR: begin
        uses_rs = 1'b1; ctrl.jump = 1'b1;
      end
      default: ;
    endcase
    ctrl.legal = (op <= OP_JR);
  end

endmodule

// File: rtl/pipe_decode.sv
// Pipelined decode stage: register read with WB bypass, immediate extension,
// load-use stall and a backpressured ID/EX output register.
module pipe_decode #(
  parameter int DATA_W  = 16,
  parameter int CTRL_W  = decode_pkg::CTRL_W,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc2,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_wreg,
  output logic              out_wen,
  output logic              out_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc2
);
  import decode_pkg::*;

  logic [DATA_W-1:0] r_rf [8];
  logic              r_valid, r_wen, r_load;
  logic [2:0]        r_wreg;
  logic [DATA_W-1:0] r_a, r_b, r_imm, r_pc2;
  logic [CTRL_W-1:0] r_ctrl;

  logic              w_uses_rs, w_uses_rt, w_zext, w_wen, w_load;
  imm_kind_t         w_imm_kind;
  dest_sel_t         w_dest_sel;
  ctrl_t             w_ctrl;
  logic [decode_pkg::CTRL_W-1:0] w_ctrl_bits;
  logic [2:0]        w_rs, w_rt, w_dest;
  logic [DATA_W-1:0] w_a, w_b, w_imm;
  logic              w_wb_we, w_rs_hit, w_rt_hit, w_hazard, w_advance;

  assign w_rs = instr[10:8];
  assign w_rt = instr[7:5];

  decode_ctrl u_ctrl (
    .op       (instr[15:11]),
    .funct    (instr[1:0]),
    .uses_rs  (w_uses_rs),
    .uses_rt  (w_uses_rt),
    .imm_kind (w_imm_kind),
    .zext     (w_zext),
    .dest_sel (w_dest_sel),
    .wen      (w_wen),
    .load     (w_load),
    .ctrl     (w_ctrl)
  );
  assign w_ctrl_bits = w_ctrl;

  always_comb begin
    w_dest = 3'd7;
    case (w_dest_sel)
      DST_RT:  w_dest = instr[7:5];
      DST_RS:  w_dest = instr[10:8];
      DST_RD:  w_dest = instr[4:2];
      default: w_dest = 3'd7;
    endcase
  end

  // IMM11 carries jump offsets, so it ignores zext and always sign-extends.
  always_comb begin
    w_imm = '0;
    case (w_imm_kind)
      IMM5:    w_imm = w_zext ? {{(DATA_W-5){1'b0}}, instr[4:0]}
                              : {{(DATA_W-5){instr[4]}}, instr[4:0]};
      IMM8:    w_imm = w_zext ? {{(DATA_W-8){1'b0}}, instr[7:0]}
                              : {{(DATA_W-8){instr[7]}}, instr[7:0]};
      IMM11:   w_imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      default: w_imm = '0;
    endcase
  end

  assign w_wb_we = wb_en & !(ZERO_R0 && wb_reg == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (w_wb_we) begin
      r_rf[wb_reg] <= wb_data;
    end
  end

  always_comb begin
    w_a = r_rf[w_rs];
    w_b = r_rf[w_rt];
    if (BYPASS && w_wb_we && wb_reg == w_rs) w_a = wb_data;
    if (BYPASS && w_wb_we && wb_reg == w_rt) w_b = wb_data;
    if (ZERO_R0 && w_rs == 3'd0) w_a = '0;
    if (ZERO_R0 && w_rt == 3'd0) w_b = '0;
  end

  assign w_rs_hit = w_uses_rs & (w_rs == r_wreg) & !(ZERO_R0 && w_rs == 3'd0);
  assign w_rt_hit = w_uses_rt & (w_rt == r_wreg) & !(ZERO_R0 && w_rt == 3'd0);
  assign w_hazard = in_valid & r_valid & r_load & r_wen & (w_rs_hit | w_rt_hit);

  // Handshake: a transfer happens on a posedge where valid and ready are both
  // high; valid never waits on ready. Flush consumes the input even in a hazard.
  assign w_advance = !r_valid | out_ready;
  assign in_ready  = rst & w_advance & (!w_hazard | flush);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_wreg  <= '0;
      r_wen   <= 1'b0;
      r_load  <= 1'b0;
      r_ctrl  <= '0;
      r_pc2   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard || !in_valid) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= 1'b1;
        r_a     <= w_a;
        r_b     <= w_b;
        r_imm   <= w_imm;
        r_wreg  <= w_dest;
        r_wen   <= w_wen;
        r_load  <= w_load;
        r_ctrl  <= CTRL_W'(w_ctrl_bits);
        r_pc2   <= pc2;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_imm   = r_imm;
  assign out_wreg  = r_wreg;
  assign out_wen   = r_wen;
  assign out_load  = r_load;
  assign out_ctrl  = r_ctrl;
  assign out_pc2   = r_pc2;

endmodule

// File: tb/tb_pipe_decode.sv
// Bench for pipe_decode: a bypassing and a non-bypassing instance share all
// inputs; a reference model predicts each issued instruction for the monitor.
module tb_pipe_decode;

  typedef struct packed {
    logic [15:0] a, a_nb, b, b_nb, imm, pc2;
    logic [23:0] ctrl;
    logic [2:0]  wreg;
    logic        wen, load;
  } exp_t;

  typedef struct packed {
    logic        uses_rs, uses_rt;
    logic [15:0] imm;
    logic [2:0]  wreg;
    logic        wen, load;
    logic [23:0] ctrl;
  } dec_t;

  logic clk, rst, in_valid, wb_en, flush, out_ready;
  logic [15:0] instr, pc2, wb_data;
  logic [2:0]  wb_reg;

  logic        in_ready, out_valid, out_wen, out_load;
  logic [15:0] out_a, out_b, out_imm, out_pc2;
  logic [2:0]  out_wreg;
  logic [23:0] out_ctrl;

  logic        nb_in_ready, nb_valid, nb_wen, nb_load;
  logic [15:0] nb_a, nb_b, nb_imm, nb_pc2;
  logic [2:0]  nb_wreg;
  logic [23:0] nb_ctrl;

  pipe_decode #(.DATA_W(16), .CTRL_W(24), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc2(pc2), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm), .out_wreg(out_wreg), .out_wen(out_wen), .out_load(out_load),
    .out_ctrl(out_ctrl), .out_pc2(out_pc2)
  );

  pipe_decode #(.DATA_W(16), .CTRL_W(24), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .instr(instr),
    .pc2(pc2), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(nb_valid), .out_ready(out_ready), .out_a(nb_a), .out_b(nb_b),
    .out_imm(nb_imm), .out_wreg(nb_wreg), .out_wen(nb_wen), .out_load(nb_load),
    .out_ctrl(nb_ctrl), .out_pc2(nb_pc2)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [15:0] m_rf [8];
  bit          m_busy = 1'b0;
  int          m_load_dst = -1;
  bit          m_took = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Decode rules of the ISA stated as a table of plain arithmetic.
  function automatic dec_t ref_dec(input logic [15:0] ins);
    dec_t d;
    int s5, s8, s11;
    logic [3:0] alu;
    logic aimm, mrd, mwr, br, jmp, lnk, rty;
    s5  = int'(ins[4:0]);  if (s5 >= 16)    s5  -= 32;
    s8  = int'(ins[7:0]);  if (s8 >= 128)   s8  -= 256;
    s11 = int'(ins[10:0]); if (s11 >= 1024) s11 -= 2048;
    d = '0; alu = 4'd0; aimm = 0; mrd = 0; mwr = 0; br = 0; jmp = 0; lnk = 0; rty = 0;
    case (ins[15:11])
      5'd0: begin d.uses_rs = 1; d.uses_rt = 1; d.wreg = ins[4:2]; d.wen = 1; alu = {2'b00, ins[1:0]}; rty = 1; end
      5'd1: begin d.uses_rs = 1; d.imm = 16'(s5); d.wreg = ins[7:5]; d.wen = 1; aimm = 1; end
      5'd2: begin d.uses_rs = 1; d.imm = 16'(ins[4:0]); d.wreg = ins[7:5]; d.wen = 1; alu = 4'd2; aimm = 1; end
      5'd3: begin d.uses_rs = 1; d.imm = 16'(s5); d.wreg = ins[7:5]; d.wen = 1; d.load = 1; aimm = 1; mrd = 1; end
      5'd4: begin d.uses_rs = 1; d.uses_rt = 1; d.imm = 16'(s5); aimm = 1; mwr = 1; end
      5'd5: begin d.imm = 16'(ins[7:0]); d.wreg = ins[10:8]; d.wen = 1; alu = 4'd4; aimm = 1; end
      5'd6: begin d.uses_rs = 1; d.imm = 16'(s8); d.wreg = ins[10:8]; d.wen = 1; aimm = 1; end
      5'd7: begin d.uses_rs = 1; d.uses_rt = 1; d.imm = 16'(s5); alu = 4'd1; br = 1; end
      5'd8: begin d.imm = 16'(s11); d.wreg = 3'd7; d.wen = 1; jmp = 1; lnk = 1; end
      5'd9: begin d.uses_rs = 1; jmp = 1; end
      default: ;
    endcase
    d.ctrl = {12'b0, alu, aimm, mrd, mwr, br, jmp, lnk, (ins[15:11] < 5'd10), rty};
    return d;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+2 with inputs set; returns at the next posedge+2.
  task automatic drive_cycle();
    dec_t d; exp_t e; logic haz, adv, rdy; logic [2:0] rs, rt;
    #1;
    rs = instr[10:8]; rt = instr[7:5]; d = ref_dec(instr);
    haz = in_valid && m_busy && (m_load_dst >= 0) &&
          ((d.uses_rs && int'(rs) == m_load_dst) || (d.uses_rt && int'(rt) == m_load_dst));
    adv = !m_busy || out_ready;
    rdy = rst && adv && (!haz || flush);
    chk("in_ready", in_ready, rdy);
    chk("in_ready_nb", nb_in_ready, rdy);
    m_took = rdy && in_valid;
    e.a    = (wb_en && wb_reg == rs) ? wb_data : m_rf[rs];
    e.a_nb = m_rf[rs];
    e.b    = (wb_en && wb_reg == rt) ? wb_data : m_rf[rt];
    e.b_nb = m_rf[rt];
    e.imm = d.imm; e.pc2 = pc2; e.ctrl = d.ctrl; e.wreg = d.wreg; e.wen = d.wen; e.load = d.load;
    @(posedge clk);
    if (!rst) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_busy = 0; m_load_dst = -1; exp_q.delete();
    end else begin
      if (flush) begin
        if (m_busy && !out_ready) exp_q.delete();
        m_busy = 0;
      end else if (adv) begin
        if (in_valid && !haz) begin
          exp_q.push_back(e); m_busy = 1; m_load_dst = d.load ? int'(d.wreg) : -1;
        end else begin
          m_busy = 0;
        end
      end
      if (wb_en) m_rf[wb_reg] = wb_data;
    end
    #2;
  endtask

  task automatic send(input logic [15:0] ins, output int n);
    n = 0; in_valid = 1'b1; instr = ins; pc2 = 16'($urandom);
    do begin drive_cycle(); n++; end while (!m_took && n < 8);
    if (!m_took) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic         stall_prev = 1'b0;
  logic [127:0] snap;
  exp_t         me;

  function automatic logic [127:0] pack_out();
    return {out_valid, out_load, out_wen, out_wreg, out_ctrl, out_pc2, out_imm, out_b, out_a};
  endfunction

  always @(negedge clk) begin
    chk("valid", out_valid, exp_q.size() != 0);
    chk("valid_nb", nb_valid, exp_q.size() != 0);
    if (stall_prev) chk("hold", pack_out(), snap);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk("out_a", out_a, me.a);       chk("out_a_nb", nb_a, me.a_nb);
      chk("out_b", out_b, me.b);       chk("out_b_nb", nb_b, me.b_nb);
      chk("out_imm", out_imm, me.imm); chk("out_imm_nb", nb_imm, me.imm);
      chk("out_wen", out_wen, me.wen); chk("out_load", out_load, me.load);
      if (me.wen) chk("out_wreg", out_wreg, me.wreg);
      chk("out_ctrl", out_ctrl, me.ctrl);
      chk("out_pc2", out_pc2, me.pc2); chk("out_pc2_nb", nb_pc2, me.pc2);
    end
    stall_prev = rst && !flush && out_valid && !out_ready;
    snap = pack_out();
  end

  // ---------------- stimulus ----------------
  int n;
  logic [15:0] pc_b;

  initial begin
    rst = 1'b0; in_valid = 0; instr = '0; pc2 = '0; wb_en = 0; wb_reg = '0;
    wb_data = '0; flush = 0; out_ready = 1'b1;
    foreach (m_rf[i]) m_rf[i] = '0;
    @(posedge clk); #2;
    repeat (2) drive_cycle();
    chk("rst_valid", out_valid, 0); chk("rst_a", out_a, 0); chk("rst_b", out_b, 0);
    chk("rst_imm", out_imm, 0);     chk("rst_wreg", out_wreg, 0); chk("rst_wen", out_wen, 0);
    chk("rst_load", out_load, 0);   chk("rst_ctrl", out_ctrl, 0); chk("rst_pc2", out_pc2, 0);
    rst = 1'b1;

    // registers read as zero after reset
    for (int r = 1; r < 8; r++) begin
      send({5'd0, 3'(r), 3'(r), 3'd1, 2'd0}, n);
      chk("rst_rf_a", out_a, 0); chk("rst_rf_b", out_b, 0);
    end

    // back-to-back ADDI, sign extension of imm5
    send({5'd1, 3'd1, 3'd2, 5'b10000}, n); chk("b2b_n0", n, 1); chk("imm_fff0", out_imm, 16'hFFF0);
    send({5'd1, 3'd2, 3'd3, 5'b01111}, n); chk("b2b_n1", n, 1); chk("imm_000f", out_imm, 16'h000F);
    send({5'd1, 3'd3, 3'd4, 5'b11111}, n); chk("b2b_n2", n, 1); chk("imm_ffff", out_imm, 16'hFFFF);

    // same-cycle writeback to a register being read
    wb_en = 1; wb_reg = 3'd3; wb_data = 16'hBEEF;
    send({5'd1, 3'd3, 3'd1, 5'd0}, n);
    wb_en = 0;
    chk("bypass_on", out_a, 16'hBEEF); chk("bypass_off", nb_a, 16'h0000);
    send({5'd1, 3'd3, 3'd1, 5'd0}, n);
    chk("bypass_next", nb_a, 16'hBEEF);

    // load-use costs one bubble; an independent reader costs none
    send({5'd3, 3'd1, 3'd2, 5'd4}, n);
    send({5'd0, 3'd2, 3'd5, 3'd6, 2'd0}, n); chk("loaduse_cycles", n, 2);
    send({5'd3, 3'd1, 3'd2, 5'd4}, n);
    send({5'd1, 3'd3, 3'd4, 5'd7}, n);       chk("nohaz_cycles", n, 1);

    // backpressure
    drive_cycle();
    out_ready = 0;
    send({5'd2, 3'd3, 3'd1, 5'd21}, n);
    in_valid = 1; instr = {5'd6, 3'd4, 8'h80}; pc2 = 16'h1A2B; pc_b = pc2;
    repeat (3) drive_cycle();
    out_ready = 1;
    drive_cycle();
    chk("bp_took", m_took, 1);
    in_valid = 0;
    chk("bp_next_pc2", out_pc2, pc_b);

    // flush in the hazard cycle still lets WB land
    send({5'd3, 3'd1, 3'd4, 5'd0}, n);
    in_valid = 1; instr = {5'd0, 3'd4, 3'd1, 3'd6, 2'd0}; flush = 1;
    wb_en = 1; wb_reg = 3'd5; wb_data = 16'h1234;
    drive_cycle();
    flush = 0; wb_en = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    send({5'd1, 3'd5, 3'd1, 5'd0}, n);
    chk("flush_wb", out_a, 16'h1234);

    // randomized traffic including one mid-run reset with a WB write
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      instr     = {5'($urandom_range(0, 11)), 11'($urandom)};
      pc2       = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 9) < 4) || (c == 200);
      wb_reg    = 3'($urandom);
      wb_data   = 16'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = (c != 200);
      drive_cycle();
    end

    in_valid = 0; wb_en = 0; flush = 0; out_ready = 1; rst = 1;
    repeat (3) drive_cycle();
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
